// File: rtl/counter_sequencer_pkg.sv
// Shared types and helpers for the counter sequencer: FSM state encoding,
// run-mode constants and the prescaler width helper.
package counter_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  // A prescale of 1 still needs a one-bit register to keep the logic uniform.
  function automatic int unsigned presc_width(input int unsigned p);
    return (p <= 32'd1) ? 32'd1 : $clog2(p);
  endfunction

endpackage

// File: rtl/counter_sequencer_prescaler.sv
// Prescaler for the counter sequencer: free-running modulo-PRESCALE count
// while run is high; tick marks the last clock of each increment interval.
module seq_prescaler
  import counter_sequencer_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int PW = presc_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_cnt;

  // prescaler count register, wraps to zero after LAST
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (run) begin
      if (r_cnt == LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + PW'(1);
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/counter_sequencer.sv
// Sequencer for an external up counter: owns the counter's clear/enable,
// paces increments through a prescaler and pulses done at terminal count.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] tc,
  input  logic [WIDTH-1:0] count_in,
  output logic             cnt_clear,
  output logic             cnt_enable,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] periods
);

  seq_state_t       r_state;
  seq_state_t       w_next_state;
  logic [WIDTH-1:0] r_tc;
  logic             r_mode;
  logic [WIDTH-1:0] r_periods;
  logic             r_done;

  logic w_tick;
  logic w_at_tc;
  logic w_start_ok;
  logic w_term;
  logic w_clear_st;
  logic w_run_st;
  logic w_busy;

  assign w_at_tc    = (count_in == r_tc);
  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_term     = (r_state == RUN) && w_at_tc;

  seq_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clr  (stop || (r_state == CLEAR)),
    .run  ((r_state == RUN) && !w_at_tc),
    .tick (w_tick)
  );

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // next-state logic; stop overrides every other request
  always_comb begin
    w_next_state = r_state;
    if (stop) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            w_next_state = CLEAR;
          end else begin
            w_next_state = r_state;
          end
        end
        CLEAR: w_next_state = RUN;
        RUN: begin
          if (w_at_tc) begin
            w_next_state = (r_mode == MODE_PERIODIC) ? CLEAR : DONE;
          end else begin
            w_next_state = RUN;
          end
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  // state-decoded outputs
  always_comb begin
    w_clear_st = 1'b0;
    w_run_st   = 1'b0;
    w_busy     = 1'b0;
    case (r_state)
      CLEAR: begin
        w_clear_st = 1'b1;
        w_busy     = 1'b1;
      end
      RUN: begin
        w_run_st = 1'b1;
        w_busy   = 1'b1;
      end
      default: begin
        w_clear_st = 1'b0;
        w_run_st   = 1'b0;
        w_busy     = 1'b0;
      end
    endcase
  end

  // command latches, period counter and registered done pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tc      <= '0;
      r_mode    <= MODE_ONESHOT;
      r_periods <= '0;
      r_done    <= 1'b0;
    end else if (stop) begin
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start_ok) begin
        r_tc      <= tc;
        r_mode    <= mode;
        r_periods <= '0;
      end else if (w_term) begin
        r_done <= 1'b1;
        if (r_mode == MODE_PERIODIC) begin
          r_periods <= r_periods + WIDTH'(1);
        end
      end
    end
  end

  // enable is gated at terminal count so the counter never passes r_tc
  assign cnt_enable = w_run_st && w_tick && !w_at_tc;
  assign cnt_clear  = w_clear_st;
  assign busy       = w_busy;
  assign done       = r_done;
  assign periods    = r_periods;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: one instance with PRESCALE=4 and one
// with PRESCALE=1, each driving a behavioural counter model.
module tb_counter_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic       a_start = 1'b0, a_stop = 1'b0, a_mode = 1'b0;
  logic [7:0] a_tc = 8'd0;
  logic [7:0] a_count = 8'd0;
  logic       a_clear, a_en, a_busy, a_done;
  logic [7:0] a_periods;

  logic       b_start = 1'b0, b_stop = 1'b0, b_mode = 1'b0;
  logic [7:0] b_tc = 8'd0;
  logic [7:0] b_count = 8'd0;
  logic       b_clear, b_en, b_busy, b_done;
  logic [7:0] b_periods;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(8), .PRESCALE(4)) u_dut4 (
    .clk(clk), .reset(rst_n), .start(a_start), .stop(a_stop), .mode(a_mode),
    .tc(a_tc), .count_in(a_count), .cnt_clear(a_clear), .cnt_enable(a_en),
    .busy(a_busy), .done(a_done), .periods(a_periods)
  );

  counter_sequencer #(.WIDTH(8), .PRESCALE(1)) u_dut1 (
    .clk(clk), .reset(rst_n), .start(b_start), .stop(b_stop), .mode(b_mode),
    .tc(b_tc), .count_in(b_count), .cnt_clear(b_clear), .cnt_enable(b_en),
    .busy(b_busy), .done(b_done), .periods(b_periods)
  );

  // external counter datapaths, untouched by the sequencer reset
  always @(posedge clk) begin
    if (a_clear) a_count <= 8'd0;
    else if (a_en) a_count <= a_count + 8'd1;
    if (b_clear) b_count <= 8'd0;
    else if (b_en) b_count <= b_count + 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // one-shot run on the PRESCALE=4 instance; optional start pulse (tc=9) at cycle inj
  task automatic a_oneshot(input string tag, input int tcv, input int inj);
    a_start = 1'b1; a_tc = 8'(tcv); a_mode = 1'b0;
    @(negedge clk);
    a_start = 1'b0;
    for (int n = 1; n <= tcv * 4 + 4; n++) begin
      chk($sformatf("%s_clear_n%0d", tag, n), 32'(a_clear), 32'(n == 1));
      chk($sformatf("%s_en_n%0d", tag, n), 32'(a_en),
          32'((n > 1) && ((n - 1) % 4 == 0) && (n <= tcv * 4 + 1)));
      chk($sformatf("%s_busy_n%0d", tag, n), 32'(a_busy), 32'(n <= tcv * 4 + 2));
      chk($sformatf("%s_done_n%0d", tag, n), 32'(a_done), 32'(n == tcv * 4 + 3));
      if (n == inj) begin
        a_start = 1'b1; a_tc = 8'd9;
      end else begin
        a_start = 1'b0;
      end
      @(negedge clk);
    end
    chk({tag, "_count"}, 32'(a_count), 32'(tcv));
    chk({tag, "_periods"}, 32'(a_periods), 32'd0);
  endtask

  initial begin
    // reset state
    @(negedge clk);
    chk("rst_a_busy", 32'(a_busy), 32'd0);
    chk("rst_a_clear", 32'(a_clear), 32'd0);
    chk("rst_a_en", 32'(a_en), 32'd0);
    chk("rst_a_done", 32'(a_done), 32'd0);
    chk("rst_a_periods", 32'(a_periods), 32'd0);
    chk("rst_b_busy", 32'(b_busy), 32'd0);
    chk("rst_b_periods", 32'(b_periods), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    a_oneshot("os3", 3, 3);       // start while busy is ignored
    a_oneshot("done_restart", 1, 0);
    a_oneshot("tc0", 0, 0);

    // stop mid-RUN at count 2
    a_start = 1'b1; a_tc = 8'd3; a_mode = 1'b0;
    @(negedge clk);
    a_start = 1'b0;
    repeat (9) @(negedge clk);
    chk("stop_pre_count", 32'(a_count), 32'd2);
    chk("stop_pre_busy", 32'(a_busy), 32'd1);
    a_stop = 1'b1;
    @(negedge clk);
    a_stop = 1'b0;
    chk("stop_busy", 32'(a_busy), 32'd0);
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("stop_en_%0d", n), 32'(a_en), 32'd0);
      chk($sformatf("stop_done_%0d", n), 32'(a_done), 32'd0);
      @(negedge clk);
    end
    chk("stop_count_held", 32'(a_count), 32'd2);

    // stop coincident with terminal count wins
    a_start = 1'b1; a_tc = 8'd3;
    @(negedge clk);
    a_start = 1'b0;
    repeat (13) @(negedge clk);
    chk("stoptc_pre_count", 32'(a_count), 32'd3);
    chk("stoptc_pre_busy", 32'(a_busy), 32'd1);
    a_stop = 1'b1;
    @(negedge clk);
    a_stop = 1'b0;
    chk("stoptc_done", 32'(a_done), 32'd0);
    chk("stoptc_busy", 32'(a_busy), 32'd0);

    // stop and start together in IDLE
    a_stop = 1'b1; a_start = 1'b1;
    @(negedge clk);
    a_stop = 1'b0; a_start = 1'b0;
    chk("stopstart_clear", 32'(a_clear), 32'd0);
    @(negedge clk);
    chk("stopstart_busy", 32'(a_busy), 32'd0);

    // asynchronous reset mid-RUN
    a_start = 1'b1; a_tc = 8'd3;
    @(negedge clk);
    a_start = 1'b0;
    repeat (5) @(negedge clk);
    chk("arst_pre_busy", 32'(a_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(a_busy), 32'd0);
    chk("arst_clear", 32'(a_clear), 32'd0);
    chk("arst_en", 32'(a_en), 32'd0);
    chk("arst_done", 32'(a_done), 32'd0);
    chk("arst_count_kept", 32'(a_count), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a_oneshot("post_rst", 1, 0);

    // periodic, PRESCALE=1, tc=2, three periods then stop
    b_start = 1'b1; b_tc = 8'd2; b_mode = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int n = 1; n <= 13; n++) begin
      chk($sformatf("per_done_n%0d", n), 32'(b_done), 32'((n % 4 == 1) && (n >= 5)));
      chk($sformatf("per_periods_n%0d", n), 32'(b_periods), 32'((n - 1) / 4));
      chk($sformatf("per_clear_n%0d", n), 32'(b_clear), 32'(n % 4 == 1));
      chk($sformatf("per_en_n%0d", n), 32'(b_en), 32'((n % 4 == 2) || (n % 4 == 3)));
      chk($sformatf("per_busy_n%0d", n), 32'(b_busy), 32'd1);
      if (n == 13) b_stop = 1'b1;
      @(negedge clk);
    end
    b_stop = 1'b0;
    chk("per_stop_busy", 32'(b_busy), 32'd0);
    chk("per_stop_periods", 32'(b_periods), 32'd3);
    chk("per_stop_done", 32'(b_done), 32'd0);

    // accepted start zeroes periods; tc=0 one-shot
    b_start = 1'b1; b_tc = 8'd0; b_mode = 1'b0;
    @(negedge clk);
    b_start = 1'b0;
    chk("b_restart_periods", 32'(b_periods), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("b_tc0_done", 32'(b_done), 32'd1);

    // 256 periodic periods of tc=0: periods wraps to 0
    b_start = 1'b1; b_tc = 8'd0; b_mode = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int n = 1; n <= 513; n++) begin
      if (n == 3) chk("wrap_p1", 32'(b_periods), 32'd1);
      if (n == 511) chk("wrap_p255", 32'(b_periods), 32'd255);
      if (n == 513) begin
        chk("wrap_p0", 32'(b_periods), 32'd0);
        chk("wrap_done", 32'(b_done), 32'd1);
        chk("wrap_en", 32'(b_en), 32'd0);
      end
      if (n < 513) @(negedge clk);
    end
    b_stop = 1'b1;
    @(negedge clk);
    b_stop = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
